// File: rtl/rip_lsu_if.sv
// Data-memory request/acknowledge bus between the load/store unit (master)
// and the memory system (slave).
interface rip_lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/rip_lsu.sv
// Load/store unit: one data-memory transaction at a time, byte-lane steering for
// stores, aligned and extended load return, misalignment and bus-timeout faults.
module rip_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    rip_lsu_if.master   mem,
    output logic        out_valid,
    output logic [31:0] out_ldata,
    output logic        exc_misaligned,
    output logic        exc_fault
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic [31:0] tcount;

    logic        accept;
    logic        misaligned;
    logic [3:0]  strb_n;
    logic [31:0] wdata_n;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic        timeout_hit;

    // Request decode: alignment check and store lane steering from the live inputs.
    always_comb begin
        accept     = in_valid & (is_load | is_store);
        misaligned = 1'b0;
        strb_n     = 4'b1111;
        wdata_n    = wdata;
        case (funct3[1:0])
            2'b00: begin
                strb_n  = 4'b0001 << addr[1:0];
                wdata_n = {4{wdata[7:0]}};
            end
            2'b01: begin
                misaligned = addr[0];
                strb_n     = addr[1] ? 4'b1100 : 4'b0011;
                wdata_n    = {2{wdata[15:0]}};
            end
            default: begin
                misaligned = (addr[1:0] != 2'b00);
            end
        endcase
        if (!is_store) begin
            strb_n  = 4'b0000;
            wdata_n = 32'h0;
        end
    end

    // Load return: move the addressed lane down to bit 0, then extend by size/signedness.
    always_comb begin
        shifted  = mem.mem_rdata >> {off_q, 3'b000};
        load_val = shifted;
        case (size_q[1:0])
            2'b00:   load_val = size_q[2] ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = size_q[2] ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcount == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            in_ready       <= 1'b1;
            mem.mem_req    <= 1'b0;
            mem.mem_we     <= 1'b0;
            mem.mem_addr   <= 32'h0;
            mem.mem_wdata  <= 32'h0;
            mem.mem_wstrb  <= 4'b0000;
            out_valid      <= 1'b0;
            out_ldata      <= 32'h0;
            exc_misaligned <= 1'b0;
            exc_fault      <= 1'b0;
            tcount         <= 32'h0;
            size_q         <= 3'b000;
            off_q          <= 2'b00;
        end else begin
            out_valid      <= 1'b0;
            exc_misaligned <= 1'b0;
            exc_fault      <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && misaligned) begin
                        out_valid      <= 1'b1;
                        exc_misaligned <= 1'b1;
                        out_ldata      <= 32'h0;
                    end else if (accept) begin
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= is_store;
                        mem.mem_addr  <= {addr[31:2], 2'b00};
                        mem.mem_wdata <= wdata_n;
                        mem.mem_wstrb <= strb_n;
                        size_q        <= funct3;
                        off_q         <= addr[1:0];
                        tcount        <= 32'h0;
                        in_ready      <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    // An ack arriving on the timeout edge still completes normally.
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        out_valid   <= 1'b1;
                        out_ldata   <= mem.mem_we ? 32'h0 : load_val;
                        in_ready    <= 1'b1;
                        state       <= IDLE;
                    end else if (timeout_hit) begin
                        mem.mem_req <= 1'b0;
                        out_valid   <= 1'b1;
                        exc_fault   <= 1'b1;
                        out_ldata   <= 32'h0;
                        in_ready    <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tcount <= tcount + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rip_lsu.sv
// Scoreboard bench for rip_lsu: a reference model predicts bus requests and
// completions, a memory responder and an output monitor check them independently.
module tb_rip_lsu;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        out_valid;
    logic [31:0] out_ldata;
    logic        exc_misaligned;
    logic        exc_fault;

    rip_lsu_if bus();

    rip_lsu #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
        .wdata(wdata), .mem(bus), .out_valid(out_valid), .out_ldata(out_ldata),
        .exc_misaligned(exc_misaligned), .exc_fault(exc_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ldata;
        logic        mis;
        logic        fault;
        int          accept_cnt;
        int          lat;
    } out_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          ack_delay;
        logic [31:0] rdata;
        int          req_len;
    } bus_exp_t;

    out_exp_t out_q[$];
    bus_exp_t bus_q[$];
    int tests = 0;
    int fails = 0;
    int cycle_count = 0;

    always @(posedge clk) cycle_count <= cycle_count + 1;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic int bytes_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Reference load result: pick the addressed bytes, then extend as the opcode demands.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rd);
        int          nbytes;
        logic [31:0] v;
        logic [31:0] mask;
        nbytes = bytes_of(f3);
        v = rd >> (8 * off);
        if (nbytes < 4) begin
            mask = (32'd1 << (8 * nbytes)) - 32'd1;
            v = v & mask;
            if (!f3[2] && v[8 * nbytes - 1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic apply_stimulus(input logic ld, input logic st, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input int ack_delay, input logic [31:0] rd);
        int       nbytes;
        int       waited;
        bit       mis;
        out_exp_t oe;
        bus_exp_t be;
        nbytes = bytes_of(f3);
        mis = (a % nbytes) != 0;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check_output("in_ready_wait", {31'h0, in_ready}, 32'h1);
        if (ld | st) begin
            oe.accept_cnt = cycle_count + 1;
            if (mis) begin
                oe.ldata = 32'h0;
                oe.mis   = 1'b1;
                oe.fault = 1'b0;
                oe.lat   = 1;
            end else begin
                be.addr  = {a[31:2], 2'b00};
                be.we    = st;
                be.wstrb = st ? 4'(((1 << nbytes) - 1) << a[1:0]) : 4'b0000;
                be.wdata = 32'h0;
                for (int i = 0; i < 4; i++) be.wdata[8*i +: 8] = wd[8*(i % nbytes) +: 8];
                be.ack_delay = ack_delay;
                be.rdata     = rd;
                be.req_len   = (ack_delay < TIMEOUT) ? ack_delay + 1 : TIMEOUT;
                oe.fault = (ack_delay >= TIMEOUT);
                oe.mis   = 1'b0;
                oe.ldata = (st || oe.fault) ? 32'h0 : model_load(f3, a[1:0], rd);
                oe.lat   = 1 + be.req_len;
                bus_q.push_back(be);
            end
            out_q.push_back(oe);
        end
        in_valid = 1'b1;
        is_load  = ld;
        is_store = st;
        funct3   = f3;
        addr     = a;
        wdata    = wd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        waited = 0;
        while ((out_q.size() != 0 || bus_q.size() != 0) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) check_output("completion_timeout", 32'(out_q.size()), 32'h0);
        if (!(ld | st)) begin
            repeat (3) begin
                @(negedge clk);
                check_output("ignored_no_req", {31'h0, bus.mem_req}, 32'h0);
                check_output("ignored_no_out", {31'h0, out_valid}, 32'h0);
            end
        end
    endtask

    // Memory responder: checks each request against the prediction and acks on schedule.
    initial begin
        bus_exp_t cur;
        int       req_cycles;
        bit       active;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        req_cycles = 0;
        active = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mem_req) begin
                if (!active && bus_q.size() == 0) begin
                    check_output("unexpected_mem_req", {31'h0, bus.mem_req}, 32'h0);
                    bus.mem_ack = 1'b0;
                end else begin
                    if (!active) begin
                        cur = bus_q.pop_front();
                        active = 1'b1;
                        req_cycles = 0;
                    end
                    check_output("mem_addr", bus.mem_addr, cur.addr);
                    check_output("mem_we", {31'h0, bus.mem_we}, {31'h0, cur.we});
                    check_output("mem_wstrb", {28'h0, bus.mem_wstrb}, {28'h0, cur.wstrb});
                    if (cur.we) check_output("mem_wdata", bus.mem_wdata, cur.wdata);
                    check_output("in_ready_busy", {31'h0, in_ready}, 32'h0);
                    req_cycles++;
                    bus.mem_ack   = (req_cycles - 1 == cur.ack_delay);
                    bus.mem_rdata = bus.mem_ack ? cur.rdata : $urandom();
                end
            end else begin
                if (active) begin
                    check_output("req_length", 32'(req_cycles), 32'(cur.req_len));
                    active = 1'b0;
                end
                bus.mem_ack = 1'b0;
            end
        end
    end

    // Output monitor: every completion pulse must match the oldest prediction.
    initial begin
        out_exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (out_q.size() == 0) begin
                    check_output("unexpected_out_valid", {31'h0, out_valid}, 32'h0);
                end else begin
                    e = out_q.pop_front();
                    check_output("out_ldata", out_ldata, e.ldata);
                    check_output("exc_misaligned", {31'h0, exc_misaligned}, {31'h0, e.mis});
                    check_output("exc_fault", {31'h0, exc_fault}, {31'h0, e.fault});
                    check_output("latency", 32'(cycle_count - e.accept_cnt + 1), 32'(e.lat));
                    check_output("in_ready_done", {31'h0, in_ready}, 32'h1);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus_exp_t    be;
        logic [2:0]  f3s[5];
        int          sel;
        logic [2:0]  f3;
        logic [31:0] a;
        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_in_ready", {31'h0, in_ready}, 32'h1);
        check_output("reset_mem_req", {31'h0, bus.mem_req}, 32'h0);
        check_output("reset_out_valid", {31'h0, out_valid}, 32'h0);
        check_output("reset_out_ldata", out_ldata, 32'h0);
        check_output("reset_exc", {30'h0, exc_misaligned, exc_fault}, 32'h0);
        check_output("reset_wstrb", {28'h0, bus.mem_wstrb}, 32'h0);
        rst_n = 1'b1;

        apply_stimulus(1, 0, 3'b010, 32'h0000_1000, 32'h0, 3, 32'hDEADBEEF);
        apply_stimulus(1, 0, 3'b000, 32'h0000_1003, 32'h0, 0, 32'h80123456);
        apply_stimulus(1, 0, 3'b100, 32'h0000_1003, 32'h0, 1, 32'h80123456);
        apply_stimulus(1, 0, 3'b101, 32'h0000_1002, 32'h0, 0, 32'h80123456);
        apply_stimulus(0, 1, 3'b001, 32'h0000_2002, 32'h1234ABCD, 2, 32'h0);
        apply_stimulus(1, 0, 3'b010, 32'h0000_1001, 32'h0, 0, 32'h0);
        apply_stimulus(0, 1, 3'b000, 32'h0000_1001, 32'h000000A5, 0, 32'h0);
        apply_stimulus(1, 0, 3'b010, 32'h0000_1004, 32'h0, 99, 32'h0);
        apply_stimulus(1, 0, 3'b001, 32'h0000_1006, 32'h0, 3, 32'h8001_7FFF);
        apply_stimulus(0, 0, 3'b010, 32'h0000_1008, 32'h0, 0, 32'h0);
        apply_stimulus(1, 1, 3'b010, 32'h0000_2008, 32'hCAFEF00D, 1, 32'h0);
        apply_stimulus(1, 0, 3'b001, 32'h0000_1005, 32'h0, 0, 32'h0);

        // Reset lands two cycles into a load that is never acknowledged.
        @(negedge clk);
        be.addr = 32'h0000_3000;
        be.we = 1'b0;
        be.wstrb = 4'b0000;
        be.wdata = 32'h0;
        be.ack_delay = 99;
        be.rdata = 32'h0;
        be.req_len = 2;
        bus_q.push_back(be);
        in_valid = 1'b1;
        is_load = 1'b1;
        funct3 = 3'b010;
        addr = 32'h0000_3000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        is_load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("rst_mid_mem_req", {31'h0, bus.mem_req}, 32'h0);
        check_output("rst_mid_out_valid", {31'h0, out_valid}, 32'h0);
        check_output("rst_mid_in_ready", {31'h0, in_ready}, 32'h1);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_output("rst_mid_quiet", {31'h0, out_valid}, 32'h0);
        end
        apply_stimulus(1, 0, 3'b010, 32'h0000_4000, 32'h0, 0, 32'h1357_9BDF);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            a = $urandom();
            if (sel == 0) begin
                apply_stimulus(0, 0, f3s[$urandom_range(0, 4)], a, $urandom(), 0, 32'h0);
            end else if (sel == 1) begin
                f3 = f3s[$urandom_range(0, 2)];
                apply_stimulus(1, 1, f3, a, $urandom(), $urandom_range(0, 5), 32'h0);
            end else if (sel < 6) begin
                f3 = f3s[$urandom_range(0, 4)];
                apply_stimulus(1, 0, f3, a, 32'h0, $urandom_range(0, 5), $urandom());
            end else begin
                f3 = f3s[$urandom_range(0, 2)];
                apply_stimulus(0, 1, f3, a, $urandom(), $urandom_range(0, 5), 32'h0);
            end
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
